regfile_checker: RTL and testbench

REGFILE_CHECKER -- requirements
Module: regfile_checker

---
 rtl/regfile_checker_pkg.sv | 29 ++
 rtl/regfile_checker_table.sv | 67 ++++++
 rtl/regfile_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_regfile_checker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_checker_pkg.sv
// regfile_checker_pkg
//   Shared types for the register-file checker: the FSM state encoding and
//   the expected-table entry struct.
//   The entry struct is sized for the widest supported configuration
//   (MAX_DATA_W data bits, MAX_REG_W register-index bits). Narrower
//   instances zero-extend into it and use only the low bits.
//   DATA_WIDTH must not exceed MAX_DATA_W, and REG_ADDR_W must not exceed
//   MAX_REG_W.

package regfile_checker_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_REG_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_CHK_REQ = 3'd2,
        S_CHK_CMP = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_W-1:0]  reg_idx;
        logic [MAX_DATA_W-1:0] value;
    } check_entry_t;

endpackage

// File: rtl/regfile_checker_table.sv
// regfile_checker_table
//   Expected-value table with NUM_CHECKS entries, one write port and one
//   combinational read port.
//   A write lands on the next rising edge, so a read in the same cycle
//   returns the old contents. Reset clears every valid bit; the register
//   index and value fields are not reset.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   wr_en/wr_idx/wr_valid/
//   wr_reg/wr_value          table write port
//   rd_idx                   read index
//   rd_entry                 entry at rd_idx, zero-extended into check_entry_t

module regfile_checker_table
    import regfile_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_CHECKS = 8,
    localparam int IDX_W     = $clog2(NUM_CHECKS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  wr_valid,
    input  logic [REG_ADDR_W-1:0] wr_reg,
    input  logic [DATA_WIDTH-1:0] wr_value,
    input  logic [IDX_W-1:0]      rd_idx,
    output check_entry_t          rd_entry
);

    logic [NUM_CHECKS-1:0] valid_q, valid_d;
    logic [REG_ADDR_W-1:0] reg_q   [NUM_CHECKS];
    logic [REG_ADDR_W-1:0] reg_d   [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] value_q [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] value_d [NUM_CHECKS];

    always_comb begin
        valid_d = valid_q;
        reg_d   = reg_q;
        value_d = value_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            reg_d[wr_idx]   = wr_reg;
            value_d[wr_idx] = wr_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
        reg_q   <= reg_d;
        value_q <= value_d;
    end

    always_comb begin
        rd_entry         = '0;
        rd_entry.valid   = valid_q[rd_idx];
        rd_entry.reg_idx = MAX_REG_W'(reg_q[rd_idx]);
        rd_entry.value   = MAX_DATA_W'(value_q[rd_idx]);
    end

endmodule

// File: rtl/regfile_checker.sv
// regfile_checker
//   Runs a processor for a programmed number of cycles, freezes it, then
//   reads back selected registers over a debug port and compares them with
//   an expected-value table.
// Ports:
//   clock, reset             clock, synchronous active-high reset
//   start, cycle_limit       launch a run of cycle_limit cycles (sampled at start)
//   exp_wr_*                 expected-table write port
//   dut_reset, dut_hold      processor reset (IDLE) and freeze (checking/DONE)
//   dbg_rd_en/addr/data      regfile debug read, data returned one cycle later
//   busy, done, pass         run status; pass = no errors and at least one check
//   error_count, checks_done saturating counters
//   fail_*                   first-mismatch capture
//   dbg_state                current FSM state
// Handshake: dbg_rd_en is a single-cycle request issued in CHK_REQ; the
//   processor must present dbg_rd_data on the following cycle (CHK_CMP),
//   where it is compared. There is no backpressure on the debug port.
// Configuration: define REGFILE_CHECKER_FAIL_CAPTURE_EN to build the
//   first-mismatch capture registers; otherwise fail_* are tied to 0.

module regfile_checker
    import regfile_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_CHECKS = 8,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = $clog2(NUM_CHECKS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_W-1:0]      cycle_limit,
    input  logic                  exp_wr_en,
    input  logic [IDX_W-1:0]      exp_wr_idx,
    input  logic                  exp_wr_valid,
    input  logic [REG_ADDR_W-1:0] exp_wr_reg,
    input  logic [DATA_WIDTH-1:0] exp_wr_value,
    output logic                  dut_reset,
    output logic                  dut_hold,
    output logic                  dbg_rd_en,
    output logic [REG_ADDR_W-1:0] dbg_rd_addr,
    input  logic [DATA_WIDTH-1:0] dbg_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      error_count,
    output logic [CNT_W-1:0]      checks_done,
    output logic                  fail_valid,
    output logic [REG_ADDR_W-1:0] fail_reg,
    output logic [DATA_WIDTH-1:0] fail_expected,
    output logic [DATA_WIDTH-1:0] fail_actual,
    output state_t                dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] chk_q, chk_d;

    check_entry_t          rd_entry;
    logic [DATA_WIDTH-1:0] exp_value;
    logic                  start_accept;
    logic                  mismatch;
    logic                  unused_entry_bits;

    regfile_checker_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_table (
        .clk      (clock),
        .reset    (reset),
        .wr_en    (exp_wr_en),
        .wr_idx   (exp_wr_idx),
        .wr_valid (exp_wr_valid),
        .wr_reg   (exp_wr_reg),
        .wr_value (exp_wr_value),
        .rd_idx   (idx_q),
        .rd_entry (rd_entry)
    );

    // Upper struct bits beyond this instance's widths are always zero.
    assign unused_entry_bits = ^rd_entry;

    assign exp_value    = rd_entry.value[DATA_WIDTH-1:0];
    assign start_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign mismatch     = (state_q == S_CHK_CMP) && (dbg_rd_data != exp_value);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        limit_d     = limit_q;
        idx_d       = idx_q;
        err_d       = err_q;
        chk_d       = chk_q;
        dbg_rd_en   = 1'b0;
        dbg_rd_addr = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_accept) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                    limit_d = cycle_limit;
                    idx_d   = '0;
                    err_d   = '0;
                    chk_d   = '0;
                end
            end
            S_RUN: begin
                // Leaves after cycle_limit cycles; a limit of 0 still spends
                // one cycle here.
                cyc_d = cyc_q + 1'b1;
                if (cyc_d >= limit_q) begin
                    state_d = S_CHK_REQ;
                end
            end
            S_CHK_REQ: begin
                if (rd_entry.valid) begin
                    dbg_rd_en   = 1'b1;
                    dbg_rd_addr = rd_entry.reg_idx[REG_ADDR_W-1:0];
                    state_d     = S_CHK_CMP;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_CHK_CMP: begin
                if (chk_q != '1) begin
                    chk_d = chk_q + 1'b1;
                end
                if (mismatch && (err_q != '1)) begin
                    err_d = err_q + 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_CHK_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            limit_q <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            chk_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            limit_q <= limit_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
        end
    end

    assign dut_reset   = (state_q == S_IDLE);
    assign dut_hold    = (state_q == S_CHK_REQ) || (state_q == S_CHK_CMP) || (state_q == S_DONE);
    assign busy        = (state_q == S_RUN) || (state_q == S_CHK_REQ) || (state_q == S_CHK_CMP);
    assign done        = (state_q == S_DONE);
    assign pass        = done && (err_q == '0) && (chk_q != '0);
    assign error_count = err_q;
    assign checks_done = chk_q;
    assign dbg_state   = state_q;

`ifdef REGFILE_CHECKER_FAIL_CAPTURE_EN
    logic                  fail_valid_q, fail_valid_d;
    logic [REG_ADDR_W-1:0] fail_reg_q, fail_reg_d;
    logic [DATA_WIDTH-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_WIDTH-1:0] fail_act_q, fail_act_d;

    // The compared register index is the one requested in CHK_REQ, which is
    // still the entry at idx_q during CHK_CMP.
    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_reg_d   = fail_reg_q;
        fail_exp_d   = fail_exp_q;
        fail_act_d   = fail_act_q;
        if (start_accept) begin
            fail_valid_d = 1'b0;
            fail_reg_d   = '0;
            fail_exp_d   = '0;
            fail_act_d   = '0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_reg_d   = rd_entry.reg_idx[REG_ADDR_W-1:0];
            fail_exp_d   = exp_value;
            fail_act_d   = dbg_rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fail_valid_q <= 1'b0;
            fail_reg_q   <= '0;
            fail_exp_q   <= '0;
            fail_act_q   <= '0;
        end else begin
            fail_valid_q <= fail_valid_d;
            fail_reg_q   <= fail_reg_d;
            fail_exp_q   <= fail_exp_d;
            fail_act_q   <= fail_act_d;
        end
    end

    assign fail_valid    = fail_valid_q;
    assign fail_reg      = fail_reg_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;
`else
    assign fail_valid    = 1'b0;
    assign fail_reg      = '0;
    assign fail_expected = '0;
    assign fail_actual   = '0;
`endif

endmodule

// File: tb/tb_regfile_checker.sv
// tb_regfile_checker
//   Directed bench for regfile_checker: a simple processor register-file
//   model answers debug reads one cycle after the request, and a negedge
//   monitor counts free-running processor cycles and debug read pulses.

module tb_regfile_checker;
    import regfile_checker_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NC  = 8;
    localparam int CW  = 16;
    localparam int IW  = $clog2(NC);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cycle_limit = '0;
    logic          exp_wr_en = 1'b0;
    logic [IW-1:0] exp_wr_idx = '0;
    logic          exp_wr_valid = 1'b0;
    logic [AW-1:0] exp_wr_reg = '0;
    logic [DW-1:0] exp_wr_value = '0;
    logic          dut_reset, dut_hold, dbg_rd_en;
    logic [AW-1:0] dbg_rd_addr;
    logic [DW-1:0] dbg_rd_data = '0;
    logic          busy, done, pass, fail_valid;
    logic [CW-1:0] error_count, checks_done;
    logic [AW-1:0] fail_reg;
    logic [DW-1:0] fail_expected, fail_actual;
    state_t        dbg_state;

    regfile_checker #(
        .DATA_WIDTH (DW), .REG_ADDR_W (AW), .NUM_CHECKS (NC), .CNT_W (CW)
    ) dut (
        .clock         (clk),
        .reset         (reset),
        .start         (start),
        .cycle_limit   (cycle_limit),
        .exp_wr_en     (exp_wr_en),
        .exp_wr_idx    (exp_wr_idx),
        .exp_wr_valid  (exp_wr_valid),
        .exp_wr_reg    (exp_wr_reg),
        .exp_wr_value  (exp_wr_value),
        .dut_reset     (dut_reset),
        .dut_hold      (dut_hold),
        .dbg_rd_en     (dbg_rd_en),
        .dbg_rd_addr   (dbg_rd_addr),
        .dbg_rd_data   (dbg_rd_data),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .error_count   (error_count),
        .checks_done   (checks_done),
        .fail_valid    (fail_valid),
        .fail_reg      (fail_reg),
        .fail_expected (fail_expected),
        .fail_actual   (fail_actual),
        .dbg_state     (dbg_state)
    );

    // ---------------- processor model ----------------
    logic [DW-1:0] rf [32];
    always @(posedge clk) dbg_rd_data <= rf[dbg_rd_addr];

    int run_cyc  = 0;
    int rd_pulse = 0;
    always @(negedge clk) begin
        if (!reset && !dut_reset && !dut_hold) run_cyc = run_cyc + 1;
        if (!reset && dbg_rd_en) rd_pulse = rd_pulse + 1;
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_entry(input int idx, input logic v, input int r, input logic [DW-1:0] val);
        exp_wr_en    = 1'b1;
        exp_wr_idx   = IW'(idx);
        exp_wr_valid = v;
        exp_wr_reg   = AW'(r);
        exp_wr_value = val;
        tick();
        exp_wr_en    = 1'b0;
    endtask

    task automatic load_main_table();
        write_entry(0, 1'b1, 1, 32'd3);
        write_entry(1, 1'b1, 2, 32'd3);
        write_entry(2, 1'b1, 3, 32'd6);
        write_entry(3, 1'b1, 7, 32'hFFFF_FF9D);
        write_entry(4, 1'b1, 8, 32'd666);
        write_entry(5, 1'b1, 9, 32'd999);
    endtask

    task automatic load_main_model();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[1] = 32'd3;
        rf[2] = 32'd3;
        rf[3] = 32'd6;
        rf[7] = 32'hFFFF_FF9D;
        rf[8] = 32'd666;
        rf[9] = 32'd999;
    endtask

    task automatic launch(input int limit);
        run_cyc      = 0;
        rd_pulse     = 0;
        cycle_limit  = CW'(limit);
        start        = 1'b1;
        tick();
        start        = 1'b0;
        cycle_limit  = CW'($urandom_range(1, 5));
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!done && cycles < 500) begin
            tick();
            cycles++;
        end
        if (!done) check({tag, "_timeout"}, 64'(done), 64'd1);
    endtask

    // ---------------- directed sequence ----------------
    int cyc;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        do_reset();

        // Reset state
        check("rst_dut_reset", 64'(dut_reset), 64'd1);
        check("rst_dut_hold",  64'(dut_hold),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_pass",      64'(pass),      64'd0);
        check("rst_rd_en",     64'(dbg_rd_en), 64'd0);
        check("rst_err",       64'(error_count), 64'd0);
        check("rst_chk",       64'(checks_done), 64'd0);
        check("rst_fail_valid", 64'(fail_valid), 64'd0);

        // Matching model, 20-cycle run
        load_main_table();
        load_main_model();
        launch(20);
        check("run_busy",  64'(busy),      64'd1);
        check("run_state", 64'(dbg_state), 64'(S_RUN));
        wait_done("t1", cyc);
        check("t1_run_cycles", 64'(run_cyc),     64'd20);
        check("t1_rd_pulses",  64'(rd_pulse),    64'd6);
        check("t1_checks",     64'(checks_done), 64'd6);
        check("t1_errors",     64'(error_count), 64'd0);
        check("t1_pass",       64'(pass),        64'd1);
        check("t1_done",       64'(done),        64'd1);
        check("t1_hold",       64'(dut_hold),    64'd1);
        check("t1_dut_reset",  64'(dut_reset),   64'd0);
        check("t1_busy",       64'(busy),        64'd0);

        // One wrong register, restarted from DONE
        rf[8] = 32'd665;
        launch(20);
        check("t2_chk_cleared",  64'(checks_done), 64'd0);
        check("t2_done_cleared", 64'(done),        64'd0);
        check("t2_pass_cleared", 64'(pass),        64'd0);
        wait_done("t2", cyc);
        check("t2_errors", 64'(error_count), 64'd1);
        check("t2_checks", 64'(checks_done), 64'd6);
        check("t2_pass",   64'(pass),        64'd0);
`ifdef REGFILE_CHECKER_FAIL_CAPTURE_EN
        check("t2_fail_valid", 64'(fail_valid),    64'd1);
        check("t2_fail_reg",   64'(fail_reg),      64'd8);
        check("t2_fail_exp",   64'(fail_expected), 64'd666);
        check("t2_fail_act",   64'(fail_actual),   64'd665);
`else
        check("t2_fail_valid", 64'(fail_valid),    64'd0);
        check("t2_fail_reg",   64'(fail_reg),      64'd0);
        check("t2_fail_exp",   64'(fail_expected), 64'd0);
        check("t2_fail_act",   64'(fail_actual),   64'd0);
`endif

        // start during RUN is ignored; run length stays 10
        rf[8] = 32'd666;
        launch(10);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t3", cyc);
        check("t3_run_cycles", 64'(run_cyc),     64'd10);
        check("t3_pass",       64'(pass),        64'd1);
        check("t3_fail_valid", 64'(fail_valid),  64'd0);

        // Only first and last index valid
        do_reset();
        write_entry(0, 1'b1, 4,  32'h0000_1234);
        write_entry(7, 1'b1, 31, 32'hDEAD_BEEF);
        rf[4]  = 32'h0000_1234;
        rf[31] = 32'hDEAD_BEEF;
        launch(2);
        wait_done("t4", cyc);
        check("t4_rd_pulses", 64'(rd_pulse),    64'd2);
        check("t4_checks",    64'(checks_done), 64'd2);
        check("t4_pass",      64'(pass),        64'd1);

        // Empty table, cycle_limit 0: 1 RUN cycle + NC scan cycles
        do_reset();
        launch(0);
        wait_done("t5", cyc);
        check("t5_cycles",    64'(cyc),         64'(1 + NC));
        check("t5_run_cycles", 64'(run_cyc),    64'd1);
        check("t5_checks",    64'(checks_done), 64'd0);
        check("t5_pass",      64'(pass),        64'd0);
        check("t5_done",      64'(done),        64'd1);

        // Reset asserted mid-compare
        load_main_table();
        load_main_model();
        launch(2);
        cyc = 0;
        while (!(dbg_state == S_CHK_CMP && checks_done == 1) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("t6_reached_cmp", 64'(dbg_state), 64'(S_CHK_CMP));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_state",     64'(dbg_state),   64'(S_IDLE));
        check("t6_dut_reset", 64'(dut_reset),   64'd1);
        check("t6_checks",    64'(checks_done), 64'd0);
        check("t6_errors",    64'(error_count), 64'd0);
        check("t6_busy",      64'(busy),        64'd0);
        // Valid bits cleared: a fresh run finds nothing to check
        launch(0);
        wait_done("t6b", cyc);
        check("t6_no_valid_pulses", 64'(rd_pulse),    64'd0);
        check("t6_no_valid_checks", 64'(checks_done), 64'd0);
        check("t6_no_valid_pass",   64'(pass),        64'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
